// File: rtl/dma_cmd_splitter.sv
// rtl/dma_cmd_splitter.sv - splits DMA commands into chunks bounded by MAX_CHUNK and BOUNDARY
module dma_cmd_splitter #(
    parameter int MAX_CHUNK = 4096,
    parameter int BOUNDARY  = 4096
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s_axis_cmd_valid,
    output logic        s_axis_cmd_ready,
    input  logic [63:0] s_axis_cmd_address,
    input  logic [31:0] s_axis_cmd_length,
    output logic        m_axis_cmd_valid,
    input  logic        m_axis_cmd_ready,
    output logic [63:0] m_axis_cmd_address,
    output logic [31:0] m_axis_cmd_length,
    output logic        m_axis_cmd_last,
    output logic        busy,
    output logic [31:0] cmd_count,
    output logic [31:0] chunk_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    localparam logic [32:0] MAX_W    = 33'(MAX_CHUNK);
    localparam logic [32:0] BND_W    = 33'(BOUNDARY);
    localparam logic [32:0] BND_MASK = BND_W - 33'd1;

    state_t      state;
    state_t      state_next;
    logic [63:0] cur_addr;
    logic [31:0] remaining;
    logic [31:0] cmd_cnt;
    logic [31:0] chunk_cnt;
    logic        armed;

    logic [32:0] offset;
    logic [32:0] to_bnd;
    logic [32:0] lim;
    logic [31:0] chunk;
    logic        is_last;
    logic        ready_int;
    logic        valid_int;
    logic        take_cmd;
    logic        take_chunk;

    // All size arithmetic is 33 bits wide so a 4 GiB boundary distance never truncates.
    always_comb begin
        offset  = {1'b0, cur_addr[31:0]} & BND_MASK;
        to_bnd  = BND_W - offset;
        lim     = (MAX_W < to_bnd) ? MAX_W : to_bnd;
        chunk   = ({1'b0, remaining} < lim) ? remaining : lim[31:0];
        is_last = (chunk == remaining);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_int  = 1'b0;
        valid_int  = 1'b0;
        case (state)
            IDLE: begin
                ready_int = armed;
                if (armed && s_axis_cmd_valid && (s_axis_cmd_length != 32'd0)) begin
                    state_next = SPLIT;
                end
            end
            SPLIT: begin
                valid_int = 1'b1;
                if (m_axis_cmd_ready && is_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign take_cmd   = ready_int && s_axis_cmd_valid && (s_axis_cmd_length != 32'd0);
    assign take_chunk = valid_int && m_axis_cmd_ready;

    // armed keeps ready low until the first clock edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            armed     <= 1'b0;
            cur_addr  <= 64'd0;
            remaining <= 32'd0;
            cmd_cnt   <= 32'd0;
            chunk_cnt <= 32'd0;
        end else begin
            armed <= 1'b1;
            if (take_cmd) begin
                cur_addr  <= s_axis_cmd_address;
                remaining <= s_axis_cmd_length;
                cmd_cnt   <= cmd_cnt + 32'd1;
            end else if (take_chunk) begin
                cur_addr  <= cur_addr + {32'd0, chunk};
                remaining <= remaining - chunk;
                chunk_cnt <= chunk_cnt + 32'd1;
            end
        end
    end

    assign s_axis_cmd_ready   = ready_int;
    assign m_axis_cmd_valid   = valid_int;
    assign m_axis_cmd_address = cur_addr;
    assign m_axis_cmd_length  = chunk;
    assign m_axis_cmd_last    = valid_int && is_last;
    assign busy               = (state == SPLIT);
    assign cmd_count          = cmd_cnt;
    assign chunk_count        = chunk_cnt;

endmodule

// File: tb/tb_dma_cmd_splitter.sv
// tb/tb_dma_cmd_splitter.sv - directed and randomized-backpressure bench for dma_cmd_splitter
module tb_dma_cmd_splitter;

    logic        aclk;
    logic        aresetn;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_addr;
    logic [31:0] s_len;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_addr;
    logic [31:0] m_len;
    logic        m_last;
    logic        busy;
    logic [31:0] cmd_count;
    logic [31:0] chunk_count;

    dma_cmd_splitter #(.MAX_CHUNK(4096), .BOUNDARY(4096)) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .s_axis_cmd_valid  (s_valid),
        .s_axis_cmd_ready  (s_ready),
        .s_axis_cmd_address(s_addr),
        .s_axis_cmd_length (s_len),
        .m_axis_cmd_valid  (m_valid),
        .m_axis_cmd_ready  (m_ready),
        .m_axis_cmd_address(m_addr),
        .m_axis_cmd_length (m_len),
        .m_axis_cmd_last   (m_last),
        .busy              (busy),
        .cmd_count         (cmd_count),
        .chunk_count       (chunk_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0]       addr;
        logic [31:0]       len;
        int                n;
        logic [3:0][63:0]  ca;
        logic [3:0][31:0]  cl;
    } vec_t;

    vec_t vecs[6];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_cmds = 0;
    int   exp_chunks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic set_vec(input int i, input logic [63:0] a, input logic [31:0] l, input int n,
                           input logic [63:0] a0, input logic [31:0] l0,
                           input logic [63:0] a1, input logic [31:0] l1,
                           input logic [63:0] a2, input logic [31:0] l2);
        vecs[i].addr = a;  vecs[i].len = l;  vecs[i].n = n;
        vecs[i].ca[0] = a0; vecs[i].cl[0] = l0;
        vecs[i].ca[1] = a1; vecs[i].cl[1] = l1;
        vecs[i].ca[2] = a2; vecs[i].cl[2] = l2;
        vecs[i].ca[3] = 64'd0; vecs[i].cl[3] = 32'd0;
    endtask

    // Presents a command and returns on the negedge after its handshake edge.
    task automatic issue(input logic [63:0] a, input logic [31:0] l);
        int n;
        @(negedge aclk);
        s_valid = 1'b1; s_addr = a; s_len = l;
        n = 0;
        while (!s_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 50) chk("issue_timeout", 64'(s_ready), 64'd1);
        @(negedge aclk);
        s_valid = 1'b0;
    endtask

    initial begin
        int got, cyc;
        logic done;
        logic [63:0] h_a;
        logic [31:0] h_l;
        logic        h_last;
        int stab_err, valid_err, order_err, bnd_err, size_err, sum_err, stale;
        logic [63:0] nxt, ra;
        logic [31:0] rl;
        longint sum;
        logic stalled;

        aresetn = 1'b0; s_valid = 1'b0; s_addr = '0; s_len = '0; m_ready = 1'b0;

        set_vec(0, 64'h0, 32'd64, 1, 64'h0, 32'd64, 64'h0, 32'd0, 64'h0, 32'd0);
        set_vec(1, 64'h1000, 32'd10000, 3, 64'h1000, 32'd4096, 64'h2000, 32'd4096, 64'h3000, 32'd1808);
        set_vec(2, 64'h0FF0, 32'h40, 2, 64'h0FF0, 32'h10, 64'h1000, 32'h30, 64'h0, 32'd0);
        set_vec(3, 64'hFFFF_FFFF_FFFF_F800, 32'h1000, 2, 64'hFFFF_FFFF_FFFF_F800, 32'h800, 64'h0, 32'h800, 64'h0, 32'd0);
        set_vec(4, 64'h123, 32'h2000, 3, 64'h123, 32'hEDD, 64'h1000, 32'h1000, 64'h2000, 32'h123);
        set_vec(5, 64'h7FFF, 32'd1, 1, 64'h7FFF, 32'd1, 64'h0, 32'd0, 64'h0, 32'd0);

        repeat (3) @(negedge aclk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_addr", m_addr, 64'd0);
        chk("rst_m_len", 64'(m_len), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_count", 64'(cmd_count), 64'd0);
        chk("rst_chunk_count", 64'(chunk_count), 64'd0);
        aresetn = 1'b1;
        #1 chk("ready_before_edge", 64'(s_ready), 64'd0);
        @(negedge aclk);
        chk("ready_after_edge", 64'(s_ready), 64'd1);

        issue(64'h0, 32'd0);
        chk("zero_len_no_valid", 64'(m_valid), 64'd0);
        chk("zero_len_ready", 64'(s_ready), 64'd1);
        @(negedge aclk);
        chk("zero_len_no_valid2", 64'(m_valid), 64'd0);
        chk("zero_len_cmd_count", 64'(cmd_count), 64'd0);
        chk("zero_len_chunk_count", 64'(chunk_count), 64'd0);

        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].addr, vecs[i].len);
            got = 0; cyc = 0; done = 1'b0;
            while (!done && cyc < 20) begin
                if (m_valid) begin
                    if (got < 4) begin
                        chk($sformatf("v%0d_addr%0d", i, got), m_addr, vecs[i].ca[got]);
                        chk($sformatf("v%0d_len%0d", i, got), 64'(m_len), 64'(vecs[i].cl[got]));
                        chk($sformatf("v%0d_last%0d", i, got), 64'(m_last), 64'(got == vecs[i].n - 1));
                    end
                    got++;
                    if (m_last) done = 1'b1;
                end
                cyc++;
                @(negedge aclk);
            end
            chk($sformatf("v%0d_nchunks", i), 64'(got), 64'(vecs[i].n));
            chk($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vecs[i].n));
            chk($sformatf("v%0d_bubble_ready", i), 64'(s_ready), 64'd1);
            chk($sformatf("v%0d_bubble_valid", i), 64'(m_valid), 64'd0);
            exp_cmds++;
            exp_chunks += vecs[i].n;
            chk($sformatf("v%0d_cmd_count", i), 64'(cmd_count), 64'(exp_cmds));
            chk($sformatf("v%0d_chunk_count", i), 64'(chunk_count), 64'(exp_chunks));
        end

        // Stall the first chunk and verify it is held.
        m_ready = 1'b0;
        issue(64'h1000, 32'd10000);
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_busy", 64'(busy), 64'd1);
        chk("stall_s_ready", 64'(s_ready), 64'd0);
        repeat (3) @(negedge aclk);
        chk("stall_addr", m_addr, 64'h1000);
        chk("stall_len", 64'(m_len), 64'd4096);
        chk("stall_last", 64'(m_last), 64'd0);
        m_ready = 1'b1;
        cyc = 0;
        while (!(m_valid && m_last) && cyc < 20) begin
            @(negedge aclk);
            cyc++;
        end
        chk("stall_final_addr", m_addr, 64'h3000);
        chk("stall_final_len", 64'(m_len), 64'd1808);
        @(negedge aclk);
        exp_cmds++;
        exp_chunks += 3;
        chk("stall_chunk_count", 64'(chunk_count), 64'(exp_chunks));

        stab_err = 0; valid_err = 0; order_err = 0; bnd_err = 0; size_err = 0; sum_err = 0;
        for (int c = 0; c < 300; c++) begin
            ra = {$urandom, $urandom};
            rl = (c % 3 == 0) ? 32'($urandom_range(1, 200)) : 32'($urandom_range(1, 20000));
            issue(ra, rl);
            exp_cmds++;
            sum = 0; nxt = ra; stalled = 1'b0; done = 1'b0; cyc = 0;
            while (!done && cyc < 2000) begin
                if (stalled && (m_addr !== h_a || m_len !== h_l || m_last !== h_last)) stab_err++;
                if (!m_valid) valid_err++;
                m_ready = 1'($urandom_range(0, 1));
                if (m_ready && m_valid) begin
                    if (m_addr !== nxt) order_err++;
                    if (({21'd0, m_addr[11:0]} + {1'b0, m_len}) > 33'd4096) bnd_err++;
                    if (m_len > 32'd4096 || m_len == 32'd0) size_err++;
                    sum += longint'(m_len);
                    nxt = m_addr + {32'd0, m_len};
                    exp_chunks++;
                    if (m_last) done = 1'b1;
                end
                stalled = !m_ready;
                h_a = m_addr; h_l = m_len; h_last = m_last;
                cyc++;
                @(negedge aclk);
            end
            if (sum != longint'(rl)) sum_err++;
        end
        chk("rand_sum", 64'(sum_err), 64'd0);
        chk("rand_stable", 64'(stab_err), 64'd0);
        chk("rand_valid", 64'(valid_err), 64'd0);
        chk("rand_order", 64'(order_err), 64'd0);
        chk("rand_boundary", 64'(bnd_err), 64'd0);
        chk("rand_size", 64'(size_err), 64'd0);
        chk("rand_cmd_count", 64'(cmd_count), 64'(exp_cmds));
        chk("rand_chunk_count", 64'(chunk_count), 64'(exp_chunks));

        // Reset in the middle of a 5-chunk command.
        m_ready = 1'b1;
        issue(64'h0, 32'd20480);
        chk("mid_chunk1", m_addr, 64'h0);
        @(negedge aclk);
        chk("mid_chunk2", m_addr, 64'h1000);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_ready", 64'(s_ready), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_cmd_count", 64'(cmd_count), 64'd0);
        chk("mid_rst_chunk_count", 64'(chunk_count), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_ready", 64'(s_ready), 64'd1);
        chk("post_rst_cmd_count", 64'(cmd_count), 64'd0);
        chk("post_rst_chunk_count", 64'(chunk_count), 64'd0);
        stale = 0;
        repeat (8) begin
            @(negedge aclk);
            if (m_valid) stale++;
        end
        chk("post_rst_no_stale", 64'(stale), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
